// File: rtl/cell_al_sequencer_pkg.sv
// Shared definitions for the cell_al micro-sequencer: opcode values,
// micro-instruction field layout and the sequencer state encoding.
package cell_al_sequencer_pkg;

    // Cell operation codes carried in the selOp field
    localparam logic [1:0] OP_ADD = 2'd0;
    localparam logic [1:0] OP_SUB = 2'd1;
    localparam logic [1:0] OP_AND = 2'd2;
    localparam logic [1:0] OP_OR  = 2'd3;

    // Micro-instruction bit positions
    localparam int INSTR_W    = 10;
    localparam int LAST_BIT   = 9;
    localparam int DST_HI     = 8;
    localparam int DST_LO     = 7;
    localparam int BYPASS_BIT = 6;
    localparam int SELOP_HI   = 5;
    localparam int SELOP_LO   = 4;
    localparam int SEL1_HI    = 3;
    localparam int SEL1_LO    = 2;
    localparam int SEL0_HI    = 1;
    localparam int SEL0_LO    = 0;

    // Sequencer states
    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    // Decoded micro-instruction
    typedef struct packed {
        logic       last;
        logic [1:0] dst;
        logic       by_pass;
        logic [1:0] sel_op;
        logic [1:0] sel1;
        logic [1:0] sel0;
    } instr_t;

    // Split a raw program word into its named fields
    function automatic instr_t decode_instr(input logic [INSTR_W-1:0] raw);
        instr_t ins;
        ins.last    = raw[LAST_BIT];
        ins.dst     = raw[DST_HI:DST_LO];
        ins.by_pass = raw[BYPASS_BIT];
        ins.sel_op  = raw[SELOP_HI:SELOP_LO];
        ins.sel1    = raw[SEL1_HI:SEL1_LO];
        ins.sel0    = raw[SEL0_HI:SEL0_LO];
        return ins;
    endfunction

endpackage

// File: rtl/cell_al_sequencer.sv
// Micro-sequencer for one cell_arithmetic_logic_reduced instance.
// Holds a loadable micro-program and four operand registers, issues one
// instruction per clock while running, writes each cell result back to the
// destination register and reports the final value with a done pulse.
module cell_al_sequencer #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 8,
    parameter int PC_W  = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             progWe,
    input  logic [PC_W-1:0]  progAddr,
    input  logic [9:0]       progData,
    input  logic             start,
    input  logic             abort,
    input  logic [WIDTH-1:0] opA,
    input  logic [WIDTH-1:0] opB,
    input  logic [WIDTH-1:0] opC,
    input  logic [WIDTH-1:0] opD,
    output logic [WIDTH-1:0] cellIn0,
    output logic [WIDTH-1:0] cellIn1,
    output logic [WIDTH-1:0] cellIn2,
    output logic [WIDTH-1:0] cellIn3,
    output logic [1:0]       cellSel0,
    output logic [1:0]       cellSel1,
    output logic [1:0]       cellSelOp,
    output logic             cellByPass,
    input  logic [WIDTH-1:0] cellResult,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result
);
    import cell_al_sequencer_pkg::*;

    localparam logic [PC_W-1:0] LAST_PC = PC_W'(DEPTH - 1);

    state_e                   state_q, state_d;
    logic [PC_W-1:0]          pc_q, pc_d;
    logic [WIDTH-1:0]         regs_q [4];
    logic [WIDTH-1:0]         regs_d [4];
    logic [INSTR_W-1:0]       prog_q [DEPTH];
    logic [INSTR_W-1:0]       prog_d [DEPTH];
    logic [WIDTH-1:0]         result_q, result_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    instr_t                   cur_s;

    // Next-state, program write and register write-back logic
    always_comb begin
        state_d  = state_q;
        pc_d     = pc_q;
        regs_d   = regs_q;
        prog_d   = prog_q;
        result_d = result_q;
        cur_s    = decode_instr(prog_q[pc_q]);

        case (state_q)
            ST_IDLE: begin
                // Program write lands at the same edge as start, so a run
                // begun together with a write sees the new contents.
                if (progWe) begin
                    prog_d[progAddr] = progData;
                end else begin
                    prog_d = prog_q;
                end
                if (start) begin
                    regs_d[0] = opA;
                    regs_d[1] = opB;
                    regs_d[2] = opC;
                    regs_d[3] = opD;
                    pc_d      = '0;
                    state_d   = ST_RUN;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (abort) begin
                    // Abandon the run: no write-back, result untouched
                    state_d = ST_IDLE;
                end else begin
                    regs_d[cur_s.dst] = cellResult;
                    // End of memory terminates the run; pc never wraps
                    if (cur_s.last || (pc_q == LAST_PC)) begin
                        result_d = cellResult;
                        state_d  = ST_DONE;
                    end else begin
                        pc_d = pc_q + {{(PC_W-1){1'b0}}, 1'b1};
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
        done_d = (state_d == ST_DONE);
    end

    // State, program memory and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            pc_q     <= '0;
            result_q <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                regs_q[i] <= '0;
            end
            for (int j = 0; j < DEPTH; j++) begin
                prog_q[j] <= '0;
            end
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            result_q <= result_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            regs_q   <= regs_d;
            prog_q   <= prog_d;
        end
    end

    // Cell controls follow the current instruction only while running
    always_comb begin
        cellSel0   = 2'd0;
        cellSel1   = 2'd0;
        cellSelOp  = 2'd0;
        cellByPass = 1'b0;
        if (state_q == ST_RUN) begin
            cellSel0   = cur_s.sel0;
            cellSel1   = cur_s.sel1;
            cellSelOp  = cur_s.sel_op;
            cellByPass = cur_s.by_pass;
        end else begin
            cellSel0   = 2'd0;
            cellSel1   = 2'd0;
            cellSelOp  = 2'd0;
            cellByPass = 1'b0;
        end
    end

    assign cellIn0 = regs_q[0];
    assign cellIn1 = regs_q[1];
    assign cellIn2 = regs_q[2];
    assign cellIn3 = regs_q[3];
    assign busy    = busy_q;
    assign done    = done_q;
    assign result  = result_q;

endmodule

// File: tb/tb_cell_al_sequencer.sv
// Self-checking bench for cell_al_sequencer. A behavioural cell closes the
// loop on cellResult; a reference model replays each micro-program with
// plain arithmetic and predicts operands, controls, done timing and result.
module tb_cell_al_sequencer;
    localparam int WIDTH = 32;
    localparam int DEPTH = 8;
    localparam int PC_W  = 3;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             progWe = 1'b0;
    logic [PC_W-1:0]  progAddr = '0;
    logic [9:0]       progData = '0;
    logic             start = 1'b0;
    logic             abort = 1'b0;
    logic [WIDTH-1:0] opA = '0, opB = '0, opC = '0, opD = '0;
    logic [WIDTH-1:0] cellIn0, cellIn1, cellIn2, cellIn3;
    logic [1:0]       cellSel0, cellSel1, cellSelOp;
    logic             cellByPass;
    logic [WIDTH-1:0] cellResult;
    logic             busy, done;
    logic [WIDTH-1:0] result;

    int checks = 0;
    int errors = 0;

    logic [9:0]       prog_m [DEPTH];
    logic [WIDTH-1:0] result_m = '0;

    cell_al_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .PC_W(PC_W)) dut (
        .clk(clk), .rst_n(rst_n), .progWe(progWe), .progAddr(progAddr),
        .progData(progData), .start(start), .abort(abort),
        .opA(opA), .opB(opB), .opC(opC), .opD(opD),
        .cellIn0(cellIn0), .cellIn1(cellIn1), .cellIn2(cellIn2), .cellIn3(cellIn3),
        .cellSel0(cellSel0), .cellSel1(cellSel1), .cellSelOp(cellSelOp),
        .cellByPass(cellByPass), .cellResult(cellResult),
        .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    // Behaviour of the arithmetic/logic cell: pick two operands, combine
    function automatic logic [WIDTH-1:0] cell_fn(input logic [WIDTH-1:0] i0, i1, i2, i3,
                                                 input logic [1:0] s0, s1, op,
                                                 input logic byp);
        logic [WIDTH-1:0] v [4];
        logic [WIDTH-1:0] a, b;
        v[0] = i0; v[1] = i1; v[2] = i2; v[3] = i3;
        a = v[s0];
        b = v[s1];
        if (byp) return a;
        case (op)
            2'd0:    return a + b;
            2'd1:    return a - b;
            2'd2:    return a & b;
            default: return a | b;
        endcase
    endfunction

    assign cellResult = cell_fn(cellIn0, cellIn1, cellIn2, cellIn3,
                                cellSel0, cellSel1, cellSelOp, cellByPass);

    function automatic logic [9:0] mk(input logic last, input logic [1:0] dst,
                                      input logic byp, input logic [1:0] op,
                                      input logic [1:0] s1, input logic [1:0] s0);
        return {last, dst, byp, op, s1, s0};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic write_prog(input int addr, input logic [9:0] data);
        @(negedge clk);
        progWe = 1'b1; progAddr = PC_W'(addr); progData = data;
        prog_m[addr] = data;
        @(negedge clk);
        progWe = 1'b0;
    endtask

    task automatic clear_noise();
        progWe = 1'b0; start = 1'b0;
    endtask

    task automatic set_noise();
        progWe = 1'b1; progAddr = PC_W'($urandom_range(DEPTH-1, 0));
        progData = 10'($urandom); start = 1'b1;
        opA = $urandom; opB = $urandom; opC = $urandom; opD = $urandom;
    endtask

    // Start a run and follow it cycle by cycle against the model
    task automatic run(input string tag, input logic [WIDTH-1:0] a, b, c, d,
                       input int abort_at, input bit noise,
                       input bit wr_with_start, input logic [9:0] wdata);
        logic [WIDTH-1:0] r [4];
        logic [WIDTH-1:0] res;
        logic [9:0] ins;
        bit fin;
        bit aborted;
        r[0] = a; r[1] = b; r[2] = c; r[3] = d;
        fin = 1'b0; aborted = 1'b0;
        @(negedge clk);
        opA = a; opB = b; opC = c; opD = d; start = 1'b1;
        if (wr_with_start) begin
            progWe = 1'b1; progAddr = '0; progData = wdata; prog_m[0] = wdata;
        end
        @(negedge clk);
        start = 1'b0; progWe = 1'b0;
        for (int i = 0; i < DEPTH && !fin; i++) begin
            ins = prog_m[i];
            check({tag, "_busy_run"}, 128'(busy), 128'd1);
            check({tag, "_done_run"}, 128'(done), 128'd0);
            check({tag, "_operands"}, {cellIn3, cellIn2, cellIn1, cellIn0},
                  {r[3], r[2], r[1], r[0]});
            check({tag, "_ctrl"}, 128'({cellByPass, cellSelOp, cellSel1, cellSel0}),
                  128'(ins[6:0]));
            if (i == abort_at) begin
                abort = 1'b1;
                @(negedge clk);
                abort = 1'b0;
                check({tag, "_abort_busy"}, 128'(busy), 128'd0);
                check({tag, "_abort_done"}, 128'(done), 128'd0);
                check({tag, "_abort_result"}, 128'(result), 128'(result_m));
                fin = 1'b1; aborted = 1'b1;
            end else begin
                res = cell_fn(r[0], r[1], r[2], r[3], ins[1:0], ins[3:2], ins[5:4], ins[6]);
                r[ins[8:7]] = res;
                fin = ins[9] || (i == DEPTH - 1);
                if (fin) result_m = res;
                if (noise) set_noise();
                @(negedge clk);
            end
        end
        if (!aborted) begin
            check({tag, "_done_pulse"}, 128'(done), 128'd1);
            check({tag, "_busy_done"}, 128'(busy), 128'd1);
            check({tag, "_result"}, 128'(result), 128'(result_m));
            if (noise) set_noise();
            @(negedge clk);
            clear_noise();
        end
        check({tag, "_idle_done"}, 128'(done), 128'd0);
        check({tag, "_idle_busy"}, 128'(busy), 128'd0);
        check({tag, "_idle_result"}, 128'(result), 128'(result_m));
        check({tag, "_idle_ctrl"}, 128'({cellByPass, cellSelOp, cellSel1, cellSel0}), 128'd0);
        // Make sure nothing restarts on its own
        @(negedge clk);
        check({tag, "_stay_idle"}, 128'({busy, done}), 128'd0);
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) prog_m[k] = 10'd0;
        #12;
        check("reset_busy", 128'(busy), 128'd0);
        check("reset_done", 128'(done), 128'd0);
        check("reset_result", 128'(result), 128'd0);
        check("reset_operands", {cellIn3, cellIn2, cellIn1, cellIn0}, 128'd0);
        check("reset_ctrl", 128'({cellByPass, cellSelOp, cellSel1, cellSel0}), 128'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Two-step program: (a+b) then minus b
        write_prog(0, mk(1'b0, 2'd2, 1'b0, 2'd0, 2'd1, 2'd0));
        write_prog(1, mk(1'b1, 2'd3, 1'b0, 2'd1, 2'd1, 2'd2));
        run("two_step", 32'd10, 32'd3, 32'd0, 32'd0, -1, 1'b0, 1'b0, 10'd0);
        check("two_step_value", 128'(result), 128'd10);

        // Bypass then AND
        write_prog(0, mk(1'b0, 2'd0, 1'b1, 2'd0, 2'd0, 2'd3));
        write_prog(1, mk(1'b1, 2'd1, 1'b0, 2'd2, 2'd1, 2'd0));
        run("bypass_and", $urandom, 32'h0000_FF00, $urandom, 32'h0000_F0F0, -1, 1'b0, 1'b0, 10'd0);
        check("bypass_and_value", 128'(result), 128'h0000_F000);

        // Wrap-around and end-of-memory termination
        for (int k = 0; k < DEPTH; k++) write_prog(k, mk(1'b0, 2'd0, 1'b0, 2'd0, 2'd1, 2'd0));
        run("wrap", 32'hFFFF_FFFF, 32'd1, 32'd0, 32'd0, -1, 1'b0, 1'b0, 10'd0);
        check("wrap_value", 128'(result), 128'd7);

        // Abort in the second RUN cycle, then a normal run
        run("abort", $urandom, $urandom, $urandom, $urandom, 1, 1'b0, 1'b0, 10'd0);
        run("after_abort", $urandom, $urandom, $urandom, $urandom, -1, 1'b0, 1'b0, 10'd0);

        // Writes and starts during RUN/DONE are ignored
        run("noise", $urandom, $urandom, $urandom, $urandom, -1, 1'b1, 1'b0, 10'd0);
        run("post_noise", $urandom, $urandom, $urandom, $urandom, -1, 1'b0, 1'b0, 10'd0);

        // Program write coinciding with start uses the new entry
        run("wr_start", $urandom, $urandom, $urandom, $urandom, -1, 1'b0, 1'b1,
            mk(1'b1, 2'd3, 1'b0, 2'd3, 2'd2, 2'd1));

        // Randomized programs, some aborted
        for (int t = 0; t < 8; t++) begin
            for (int k = 0; k < DEPTH; k++) begin
                logic [9:0] w;
                w = 10'($urandom);
                w[9] = ($urandom_range(3, 0) == 0);
                write_prog(k, w);
            end
            run("rand", $urandom, $urandom, $urandom, $urandom,
                (t % 3 == 2) ? int'($urandom_range(3, 0)) : -1, t[0], 1'b0, 10'd0);
        end

        // Asynchronous reset between edges in the middle of a run
        @(negedge clk);
        opA = 32'h1234_5678; opB = $urandom; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("areset_busy", 128'(busy), 128'd0);
        check("areset_done", 128'(done), 128'd0);
        check("areset_result", 128'(result), 128'd0);
        check("areset_operands", {cellIn3, cellIn2, cellIn1, cellIn0}, 128'd0);
        @(negedge clk);
        rst_n = 1'b1;
        for (int k = 0; k < DEPTH; k++) prog_m[k] = 10'd0;
        result_m = '0;
        // An all-zero program doubles r0 eight times: proves the program was cleared
        run("zero_prog", 32'h1234_5678, $urandom, $urandom, $urandom, -1, 1'b0, 1'b0, 10'd0);
        check("zero_prog_value", 128'(result), 128'h3456_7800);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
